// File: rtl/led_fader_if.sv
// led_fader_if: pattern/drive bundle between the LED register block, the
// fader and the board LED pins.
//
// Valid/ready: this bundle carries no handshake. led_in and enable are level
// signals sampled on every clock edge; led_out and busy are registered levels
// that are always valid.
//
// Signals:
//   led_in  [LED_COUNT] : target pattern, 1 = full on, 0 = off
//   enable              : 1 = fade mode, 0 = bypass
//   led_out [LED_COUNT] : PWM drive to the LED pins
//   busy                : some channel level differs from its target
//
// Modports:
//   master : pattern source (drives led_in/enable, observes led_out/busy)
//   slave  : the fader
interface led_fader_if #(
   parameter int LED_COUNT = 8
);
   logic [LED_COUNT-1:0] led_in;
   logic                 enable;
   logic [LED_COUNT-1:0] led_out;
   logic                 busy;

   modport master (output led_in, output enable, input led_out, input busy);
   modport slave  (input led_in, input enable, output led_out, output busy);
endinterface

// File: rtl/led_fader.sv
// led_fader: per-LED linear brightness fader with PWM output.
//
// Each channel keeps a PWM_BITS-wide brightness level that ramps one count
// per prescaler step toward 0 or MAX, as selected by led_in. A free-running
// PWM counter turns each level into a duty cycle on led_out. With enable low
// the levels load their targets directly every cycle (bypass).
//
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high; clears levels, counters and outputs
//   bus   : led_fader_if slave modport (led_in, enable, led_out, busy)
//
// This block has no FSM; its state is the prescaler, the PWM counter and
// the per-channel levels.
module led_fader #(
   parameter int LED_COUNT   = 8,
   parameter int PWM_BITS    = 8,
   parameter int STEP_PERIOD = 39062
) (
   input  logic        clk,
   input  logic        reset,
   led_fader_if.slave  bus
);

   localparam logic [PWM_BITS-1:0] MAX   = '1;
   localparam int                  PRE_W = (STEP_PERIOD > 1) ? $clog2(STEP_PERIOD) : 1;
   localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(STEP_PERIOD - 1);

   logic [PRE_W-1:0]    pre;
   logic [PWM_BITS-1:0] pwm;
   logic [PWM_BITS-1:0] level     [LED_COUNT];
   logic [PWM_BITS-1:0] level_nxt [LED_COUNT];
   logic [PWM_BITS-1:0] tgt       [LED_COUNT];
   logic                step;
   logic                busy_nxt;

   assign step = (pre == PRE_LAST);

   // Next level per channel; busy is computed from the value being written
   // so it drops on the same edge that the last step lands.
   always_comb begin
      busy_nxt = 1'b0;
      for (int i = 0; i < LED_COUNT; i++) begin
         tgt[i]       = bus.led_in[i] ? MAX : '0;
         level_nxt[i] = level[i];
         if (!bus.enable) begin
            level_nxt[i] = tgt[i];
         end else if (step) begin
            if (level[i] < tgt[i]) begin
               level_nxt[i] = level[i] + 1'b1;
            end else if (level[i] > tgt[i]) begin
               level_nxt[i] = level[i] - 1'b1;
            end
         end
         busy_nxt = busy_nxt | (level_nxt[i] != tgt[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pre         <= '0;
         pwm         <= '0;
         bus.led_out <= '0;
         bus.busy    <= 1'b0;
         for (int i = 0; i < LED_COUNT; i++) begin
            level[i] <= '0;
         end
      end else begin
         pre      <= step ? '0 : pre + PRE_W'(1);
         pwm      <= pwm + 1'b1;
         bus.busy <= busy_nxt;
         for (int i = 0; i < LED_COUNT; i++) begin
            level[i] <= level_nxt[i];
            // MAX term keeps a full-on LED lit during pwm == MAX as well.
            bus.led_out[i] <= (level[i] == MAX) | (level[i] > pwm);
         end
      end
   end

endmodule

// File: tb/tb_led_fader.sv
// tb_led_fader: directed self-checking bench for led_fader.
// Fast instance: PWM_BITS=4 (MAX=15), STEP_PERIOD=4.
// Slow instance: PWM_BITS=4, STEP_PERIOD=1000, used to hold a level for
// duty-cycle measurement.
module tb_led_fader;

   logic clk = 1'b0;
   logic reset;
   int   compared = 0;
   int   mismatched = 0;

   led_fader_if #(.LED_COUNT(8)) bus_f ();
   led_fader_if #(.LED_COUNT(8)) bus_s ();

   led_fader #(.LED_COUNT(8), .PWM_BITS(4), .STEP_PERIOD(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_f)
   );

   led_fader #(.LED_COUNT(8), .PWM_BITS(4), .STEP_PERIOD(1000)) dut_slow (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_s)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Leaves both DUTs just after a reset edge: pre = pwm = level = 0.
   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      bus_f.enable = 1'b1;
      bus_f.led_in = 8'h00;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      compared++;
      if (bus_f.led_out !== 8'h00 || bus_f.busy !== 1'b0 || dut.pwm !== 4'd0) begin
         mismatched++;
         $display("FAIL reset_state: led_out=%h busy=%b pwm=%0d, want 00/0/0",
                  bus_f.led_out, bus_f.busy, dut.pwm);
      end
      for (int k = 1; k <= 64; k++) begin
         tick();
         compared++;
         if (bus_f.led_out !== 8'h00 || bus_f.busy !== 1'b0 || dut.level[0] !== 4'd0) begin
            mismatched++;
            $display("FAIL idle_%0d: led_out=%h busy=%b level0=%0d, want 00/0/0",
                     k, bus_f.led_out, bus_f.busy, dut.level[0]);
         end
      end
   endtask

   task automatic test_ramp_up();
      int exp_lvl;
      do_reset();
      bus_f.enable = 1'b1;
      bus_f.led_in = 8'h01;
      for (int k = 1; k <= 60; k++) begin
         tick();
         exp_lvl = k / 4;
         compared++;
         if (dut.level[0] !== 4'(exp_lvl) || bus_f.busy !== (k < 60)) begin
            mismatched++;
            $display("FAIL ramp_up_%0d: level0=%0d busy=%b, want %0d/%b",
                     k, dut.level[0], bus_f.busy, exp_lvl, (k < 60));
         end
         compared++;
         if (bus_f.led_out[7:1] !== 7'h00) begin
            mismatched++;
            $display("FAIL ramp_up_others_%0d: led_out=%h, want bits 7:1 zero", k, bus_f.led_out);
         end
      end
      for (int k = 0; k < 32; k++) begin
         tick();
         compared++;
         if (bus_f.led_out !== 8'h01 || bus_f.busy !== 1'b0) begin
            mismatched++;
            $display("FAIL full_on_%0d: led_out=%h busy=%b, want 01/0",
                     k, bus_f.led_out, bus_f.busy);
         end
      end
   endtask

   task automatic test_pwm_duty();
      int highs;
      do_reset();
      bus_s.enable = 1'b1;
      bus_s.led_in = 8'h01;
      // Level 8 lands at edge 8000 and holds until edge 9000.
      for (int k = 0; k < 8100; k++) tick();
      compared++;
      if (dut_slow.level[0] !== 4'd8) begin
         mismatched++;
         $display("FAIL slow_level: level0=%0d, want 8", dut_slow.level[0]);
      end
      for (int w = 0; w < 3; w++) begin
         highs = 0;
         for (int k = 0; k < 16; k++) begin
            tick();
            if (bus_s.led_out[0] === 1'b1) highs++;
         end
         compared++;
         if (highs != 8) begin
            mismatched++;
            $display("FAIL duty_window_%0d: high cycles=%0d, want 8", w, highs);
         end
      end
      bus_s.led_in = 8'h00;
   endtask

   task automatic test_reverse();
      int exp0;
      int exp1;
      do_reset();
      bus_f.enable = 1'b1;
      bus_f.led_in = 8'h01;
      for (int k = 0; k < 20; k++) tick();
      compared++;
      if (dut.level[0] !== 4'd5) begin
         mismatched++;
         $display("FAIL reverse_start: level0=%0d, want 5", dut.level[0]);
      end
      bus_f.led_in = 8'h02;
      for (int m = 1; m <= 64; m++) begin
         tick();
         exp0 = (m / 4 >= 5) ? 0 : 5 - m / 4;
         exp1 = (m / 4 >= 15) ? 15 : m / 4;
         compared++;
         if (dut.level[0] !== 4'(exp0) || dut.level[1] !== 4'(exp1)
             || bus_f.busy !== (m < 60)) begin
            mismatched++;
            $display("FAIL reverse_%0d: level0=%0d level1=%0d busy=%b, want %0d/%0d/%b",
                     m, dut.level[0], dut.level[1], bus_f.busy, exp0, exp1, (m < 60));
         end
      end
   endtask

   task automatic test_bypass();
      do_reset();
      bus_f.enable = 1'b0;
      bus_f.led_in = 8'hA5;
      tick();
      compared++;
      if (bus_f.led_out !== 8'h00 || bus_f.busy !== 1'b0) begin
         mismatched++;
         $display("FAIL bypass_cycle1: led_out=%h busy=%b, want 00/0", bus_f.led_out, bus_f.busy);
      end
      for (int k = 2; k <= 10; k++) begin
         tick();
         compared++;
         if (bus_f.led_out !== 8'hA5 || bus_f.busy !== 1'b0) begin
            mismatched++;
            $display("FAIL bypass_%0d: led_out=%h busy=%b, want a5/0", k, bus_f.led_out, bus_f.busy);
         end
      end
      bus_f.enable = 1'b1;
      for (int k = 0; k < 20; k++) begin
         tick();
         compared++;
         if (bus_f.led_out !== 8'hA5 || bus_f.busy !== 1'b0) begin
            mismatched++;
            $display("FAIL bypass_resume_%0d: led_out=%h busy=%b, want a5/0",
                     k, bus_f.led_out, bus_f.busy);
         end
      end
   endtask

   task automatic test_snap();
      do_reset();
      bus_f.enable = 1'b1;
      bus_f.led_in = 8'hFF;
      for (int k = 0; k < 12; k++) tick();
      compared++;
      if (dut.level[3] !== 4'd3 || bus_f.busy !== 1'b1) begin
         mismatched++;
         $display("FAIL snap_before: level3=%0d busy=%b, want 3/1", dut.level[3], bus_f.busy);
      end
      bus_f.enable = 1'b0;
      tick();
      compared++;
      if (dut.level[3] !== 4'd15 || bus_f.busy !== 1'b0) begin
         mismatched++;
         $display("FAIL snap_edge: level3=%0d busy=%b, want 15/0", dut.level[3], bus_f.busy);
      end
      tick();
      compared++;
      if (bus_f.led_out !== 8'hFF) begin
         mismatched++;
         $display("FAIL snap_out: led_out=%h, want ff", bus_f.led_out);
      end
   endtask

   task automatic test_reset_mid_ramp();
      do_reset();
      bus_f.enable = 1'b1;
      bus_f.led_in = 8'h01;
      for (int k = 0; k < 28; k++) tick();
      compared++;
      if (dut.level[0] !== 4'd7) begin
         mismatched++;
         $display("FAIL mid_ramp_level: level0=%0d, want 7", dut.level[0]);
      end
      do_reset();
      compared++;
      if (dut.level[0] !== 4'd0 || bus_f.led_out !== 8'h00 || bus_f.busy !== 1'b0
          || dut.pwm !== 4'd0) begin
         mismatched++;
         $display("FAIL mid_ramp_reset: level0=%0d led_out=%h busy=%b pwm=%0d, want 0/00/0/0",
                  dut.level[0], bus_f.led_out, bus_f.busy, dut.pwm);
      end
      for (int k = 1; k <= 4; k++) begin
         tick();
         compared++;
         if (dut.level[0] !== 4'(k / 4) || bus_f.busy !== 1'b1) begin
            mismatched++;
            $display("FAIL restart_%0d: level0=%0d busy=%b, want %0d/1",
                     k, dut.level[0], bus_f.busy, k / 4);
         end
      end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      reset        = 1'b1;
      bus_f.enable = 1'b1;
      bus_f.led_in = 8'h00;
      bus_s.enable = 1'b1;
      bus_s.led_in = 8'h00;
      test_reset();
      test_ramp_up();
      test_pwm_duty();
      test_reverse();
      test_bypass();
      test_snap();
      test_reset_mid_ramp();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
